// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vend controller downstream of the currency accumulator
//
// Derives credit from the accumulator's running total against an internal base,
// arbitrates product selection and cancel, and runs a valid/ready dispense
// handshake. It then pays out change one coin at a time (COIN_HI, COIN_MID, 1).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   total_currency      running accumulator total (wraps mod 2^W)
//   currency_avail      accumulator update strobe (informational)
//   product_sel         product id, qualified by sel_valid (1-cycle pulse)
//   cancel              refund request (1-cycle pulse)
//   dispense_ready      product mechanism accepts the dispense request
//   coin_ready          coin return accepts the offered coin
//   credit              total_currency - base, combinational
//   busy                controller is not idle
//   dispense_valid/_id  dispense request and product id
//   coin_valid/_value   change coin request and its value
//   insufficient        1-cycle pulse, selection rejected for lack of credit
//   vend_done           1-cycle pulse, transaction complete
module vend_ctrl #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int PRICE0         = 15,
  parameter int PRICE1         = 25,
  parameter int PRICE2         = 40,
  parameter int PRICE3         = 55,
  parameter int COIN_HI        = 10,
  parameter int COIN_MID       = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CURRENCY_WIDTH-1:0] total_currency,
  input  logic                      currency_avail,
  input  logic [1:0]                product_sel,
  input  logic                      sel_valid,
  input  logic                      cancel,
  input  logic                      dispense_ready,
  input  logic                      coin_ready,
  output logic [CURRENCY_WIDTH-1:0] credit,
  output logic                      busy,
  output logic                      dispense_valid,
  output logic [1:0]                dispense_id,
  output logic                      coin_valid,
  output logic [CURRENCY_WIDTH-1:0] coin_value,
  output logic                      insufficient,
  output logic                      vend_done
);

  localparam int W = CURRENCY_WIDTH;

  localparam logic [W-1:0] P0     = W'(PRICE0);
  localparam logic [W-1:0] P1     = W'(PRICE1);
  localparam logic [W-1:0] P2     = W'(PRICE2);
  localparam logic [W-1:0] P3     = W'(PRICE3);
  localparam logic [W-1:0] C_HI   = W'(COIN_HI);
  localparam logic [W-1:0] C_MID  = W'(COIN_MID);
  localparam logic [W-1:0] C_ONE  = W'(1);
  localparam logic [W-1:0] C_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  snap_q, snap_d;
  logic [W-1:0]  change_q, change_d;
  logic [1:0]    sel_q, sel_d;
  logic          insufficient_q, insufficient_d;

  logic [W-1:0]  price;
  logic [W-1:0]  coin_amt;

  // The update strobe carries no information beyond the total itself, since
  // credit is recomputed from total_currency every cycle.
  logic unused_currency_avail;
  assign unused_currency_avail = currency_avail;

  // Modular subtraction makes a wrap of the accumulator total transparent.
  assign credit = total_currency - base_q;

  always_comb begin
    price = P0;
    case (sel_q)
      2'd0:    price = P0;
      2'd1:    price = P1;
      2'd2:    price = P2;
      default: price = P3;
    endcase
  end

  // Greedy change: largest denomination not exceeding the remaining amount.
  always_comb begin
    coin_amt = C_ONE;
    if (change_q >= C_HI) begin
      coin_amt = C_HI;
    end else if (change_q >= C_MID) begin
      coin_amt = C_MID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      snap_q         <= '0;
      change_q       <= '0;
      sel_q          <= '0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      snap_q         <= snap_d;
      change_q       <= change_d;
      sel_q          <= sel_d;
      insufficient_q <= insufficient_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    snap_d         = snap_q;
    change_d       = change_q;
    sel_d          = sel_q;
    insufficient_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Cancel takes priority over a same-cycle selection; a cancel with
        // nothing to refund is dropped so it cannot produce an empty vend.
        if (cancel && (credit != C_ZERO)) begin
          snap_d   = credit;
          change_d = credit;
          state_d  = S_CHANGE;
        end else if (sel_valid) begin
          sel_d   = product_sel;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (credit >= price) begin
          snap_d   = credit;
          change_d = credit - price;
          state_d  = S_DISPENSE;
        end else begin
          insufficient_d = 1'b1;
          state_d        = S_IDLE;
        end
      end

      S_DISPENSE: begin
        if (dispense_ready) begin
          state_d = (change_q != C_ZERO) ? S_CHANGE : S_DONE;
        end
      end

      S_CHANGE: begin
        if (coin_ready) begin
          change_d = change_q - coin_amt;
          if (change_d == C_ZERO) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Only the captured snapshot is consumed; currency inserted during
        // the transaction stays above the new base as fresh credit.
        base_d  = base_q + snap_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All handshake outputs decode registered state only.
  assign busy           = (state_q != S_IDLE);
  assign dispense_valid = (state_q == S_DISPENSE);
  assign dispense_id    = (state_q == S_DISPENSE) ? sel_q : 2'd0;
  assign coin_valid     = (state_q == S_CHANGE);
  assign coin_value     = (state_q == S_CHANGE) ? coin_amt : C_ZERO;
  assign insufficient   = insufficient_q;
  assign vend_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl
`timescale 1ns/1ps
module tb_vend_ctrl;

  localparam int EV_DISP = 0;
  localparam int EV_COIN = 1;
  localparam int EV_INS  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  typedef struct {
    int total;
    int prod;
    int sel;
    int cncl;
    int cr_before;
    int exp_busy;
    int cr_after;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] total_currency;
  logic       currency_avail;
  logic [1:0] product_sel;
  logic       sel_valid;
  logic       cancel;
  logic       dispense_ready;
  logic       coin_ready;
  logic [6:0] credit;
  logic       busy;
  logic       dispense_valid;
  logic [1:0] dispense_id;
  logic       coin_valid;
  logic [6:0] coin_value;
  logic       insufficient;
  logic       vend_done;

  int total_n = 0;
  int bad_n   = 0;
  int model_base = 0;
  int prices[4] = '{15, 25, 40, 55};
  ev_t sb[$];
  vec_t vecs[9];

  vend_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .total_currency (total_currency),
    .currency_avail (currency_avail),
    .product_sel    (product_sel),
    .sel_valid      (sel_valid),
    .cancel         (cancel),
    .dispense_ready (dispense_ready),
    .coin_ready     (coin_ready),
    .credit         (credit),
    .busy           (busy),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .insufficient   (insufficient),
    .vend_done      (vend_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_coins(input int amt);
    int a;
    int c;
    a = amt;
    while (a > 0) begin
      c = (a >= 10) ? 10 : ((a >= 5) ? 5 : 1);
      sb.push_back('{EV_COIN, c});
      a -= c;
    end
  endtask

  // Reference behaviour: what a request with this total should produce.
  task automatic push_expect(input int tot, input int prod, input int sel, input int cncl);
    int cr;
    cr = (tot - model_base) & 127;
    if (cncl != 0 && cr > 0) begin
      push_coins(cr);
      sb.push_back('{EV_DONE, 0});
      model_base = (model_base + cr) & 127;
    end else if (sel != 0) begin
      if (cr >= prices[prod]) begin
        sb.push_back('{EV_DISP, prod});
        push_coins(cr - prices[prod]);
        sb.push_back('{EV_DONE, 0});
        model_base = (model_base + cr) & 127;
      end else begin
        sb.push_back('{EV_INS, 0});
      end
    end
  endtask

  task automatic observe(input int kind, input int value);
    ev_t e;
    if (sb.size() == 0) begin
      total_n++;
      bad_n++;
      $display("FAIL sb_unexpected: got event kind %0d value %0d expected none", kind, value);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_value", value, e.value);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dispense_valid && dispense_ready) observe(EV_DISP, int'(dispense_id));
      if (coin_valid && coin_ready)         observe(EV_COIN, int'(coin_value));
      if (insufficient)                     observe(EV_INS, 0);
      if (vend_done)                        observe(EV_DONE, 0);
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, (n < 200), 1);
  endtask

  initial begin
    vecs[0] = '{total:50,  prod:2, sel:1, cncl:0, cr_before:20,  exp_busy:1, cr_after:20};
    vecs[1] = '{total:57,  prod:0, sel:0, cncl:1, cr_before:27,  exp_busy:1, cr_after:0};
    vecs[2] = '{total:69,  prod:0, sel:1, cncl:1, cr_before:12,  exp_busy:1, cr_after:0};
    vecs[3] = '{total:69,  prod:0, sel:0, cncl:1, cr_before:0,   exp_busy:0, cr_after:0};
    vecs[4] = '{total:124, prod:3, sel:1, cncl:0, cr_before:55,  exp_busy:1, cr_after:0};
    vecs[5] = '{total:10,  prod:0, sel:1, cncl:0, cr_before:14,  exp_busy:1, cr_after:14};
    vecs[6] = '{total:11,  prod:0, sel:1, cncl:0, cr_before:15,  exp_busy:1, cr_after:0};
    vecs[7] = '{total:120, prod:0, sel:0, cncl:1, cr_before:109, exp_busy:1, cr_after:0};
    vecs[8] = '{total:8,   prod:0, sel:1, cncl:0, cr_before:16,  exp_busy:1, cr_after:0};

    rst = 1'b0;
    total_currency = '0;
    currency_avail = 1'b0;
    product_sel = '0;
    sel_valid = 1'b0;
    cancel = 1'b0;
    dispense_ready = 1'b0;
    coin_ready = 1'b0;

    // Reset asserted mid-cycle.
    #3 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_dispense_valid", dispense_valid, 0);
    check("rst_dispense_id", dispense_id, 0);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_coin_value", coin_value, 0);
    check("rst_insufficient", insufficient, 0);
    check("rst_vend_done", vend_done, 0);
    check("rst_credit", credit, 0);
    total_currency = 7'd33;
    #1;
    check("rst_credit_follows", credit, 33);
    total_currency = 7'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_base = 0;

    // Vend with change: latency, dispense backpressure, coin backpressure.
    total_currency = 7'd30;
    currency_avail = 1'b1;
    tick();
    currency_avail = 1'b0;
    check("v1_credit", credit, 30);
    push_expect(30, 1, 1, 0);
    product_sel = 2'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    check("v1_busy_n1", busy, 1);
    check("v1_no_disp_n1", dispense_valid, 0);
    tick();
    check("v1_disp_n2", dispense_valid, 1);
    check("v1_id_n2", dispense_id, 1);
    repeat (3) tick();
    check("v1_disp_hold", dispense_valid, 1);
    check("v1_id_hold", dispense_id, 1);
    dispense_ready = 1'b1;
    tick();
    dispense_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("v1_coin_valid_hold", coin_valid, 1);
      check("v1_coin_value_hold", coin_value, 5);
      tick();
    end
    coin_ready = 1'b1;
    tick();
    coin_ready = 1'b0;
    check("v1_vend_done", vend_done, 1);
    tick();
    check("v1_vend_done_pulse", vend_done, 0);
    check("v1_credit_after", credit, 0);
    check("v1_sb_empty", sb.size(), 0);

    // Table-driven transactions with both mechanisms always ready.
    dispense_ready = 1'b1;
    coin_ready = 1'b1;
    for (int r = 0; r < 9; r++) begin
      total_currency = 7'(vecs[r].total);
      tick();
      check($sformatf("row%0d_credit_before", r), credit, vecs[r].cr_before);
      push_expect(vecs[r].total, vecs[r].prod, vecs[r].sel, vecs[r].cncl);
      product_sel = 2'(vecs[r].prod);
      sel_valid = (vecs[r].sel != 0);
      cancel = (vecs[r].cncl != 0);
      tick();
      sel_valid = 1'b0;
      cancel = 1'b0;
      check($sformatf("row%0d_busy", r), busy, vecs[r].exp_busy);
      repeat (3) tick();
      wait_idle($sformatf("row%0d", r));
      tick();
      check($sformatf("row%0d_credit_after", r), credit, vecs[r].cr_after);
      check($sformatf("row%0d_sb_empty", r), sb.size(), 0);
    end

    // Currency added during DISPENSE survives the transaction.
    total_currency = 7'd38;
    tick();
    check("mid_credit_before", credit, 30);
    push_expect(38, 0, 1, 0);
    dispense_ready = 1'b0;
    product_sel = 2'd0;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    check("mid_in_dispense", dispense_valid, 1);
    total_currency = 7'd48;
    tick();
    check("mid_credit_live", credit, 40);
    dispense_ready = 1'b1;
    tick();
    dispense_ready = 1'b0;
    wait_idle("mid");
    tick();
    check("mid_credit_after", credit, 10);
    check("mid_sb_empty", sb.size(), 0);

    // Reset during DISPENSE aborts without vend_done.
    total_currency = 7'd68;
    tick();
    check("abort_credit_before", credit, 30);
    product_sel = 2'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    check("abort_in_dispense", dispense_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_dispense_valid", dispense_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_coin_valid", coin_valid, 0);
    check("abort_credit", credit, 68);
    @(posedge clk);
    #1 rst = 1'b0;
    model_base = 0;
    dispense_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_vend_done", vend_done, 0);
      tick();
    end
    check("abort_idle", busy, 0);
    check("abort_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
